// File: rtl/decode_pkg.sv
// Shared opcode constants, immediate-format codes and the held-instruction record
// for the decode stage.
package decode_pkg;

  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcSystem = 7'b1110011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcOp     = 7'b0110011;

  typedef enum logic [2:0] {
    ImmNone = 3'd0,
    ImmI    = 3'd1,
    ImmS    = 3'd2,
    ImmB    = 3'd3,
    ImmU    = 3'd4,
    ImmJ    = 3'd5
  } imm_type_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    imm_type_e   imm_type;
    logic        illegal;
  } entry_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational opcode classification and sign-extended immediate extraction.
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o,
  output imm_type_e   imm_type_o,
  output logic        illegal_o
);

  always_comb begin
    imm_type_o = ImmNone;
    illegal_o  = 1'b0;
    case (instr_i[6:0])
      OpcOpImm, OpcLoad, OpcJalr, OpcSystem: imm_type_o = ImmI;
      OpcStore:                              imm_type_o = ImmS;
      OpcBranch:                             imm_type_o = ImmB;
      OpcLui, OpcAuipc:                      imm_type_o = ImmU;
      OpcJal:                                imm_type_o = ImmJ;
      OpcOp:                                 imm_type_o = ImmNone;
      default:                               illegal_o  = 1'b1;
    endcase
  end

  always_comb begin
    imm_o = '0;
    case (imm_type_o)
      ImmI: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      ImmS: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      ImmB: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                     instr_i[11:8], 1'b0};
      ImmU: imm_o = {instr_i[31:12], 12'b0};
      ImmJ: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                     instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/instr_decode_ctrl.sv
// Two-entry skid-buffered decode stage: decodes at capture, then holds
// instructions in FIFO order between fetch and execute, counting stall cycles.
module instr_decode_ctrl
  import decode_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [31:0]            in_instr_i,
  input  logic [31:0]            in_pc_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [31:0]            out_instr_o,
  output logic [31:0]            out_pc_o,
  output logic [31:0]            out_imm_o,
  output logic [2:0]             out_imm_type_o,
  output logic                   out_illegal_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e                 state_q, state_d;
  entry_t                 main_q, main_d;
  entry_t                 skid_q, skid_d;
  entry_t                 cap_entry;
  logic [31:0]            cap_imm;
  imm_type_e              cap_type;
  logic                   cap_illegal;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   in_fire, out_fire;

  imm_gen u_imm_gen (
    .instr_i    (in_instr_i),
    .imm_o      (cap_imm),
    .imm_type_o (cap_type),
    .illegal_o  (cap_illegal)
  );

  always_comb begin
    cap_entry.instr    = in_instr_i;
    cap_entry.pc       = in_pc_i;
    cap_entry.imm      = cap_imm;
    cap_entry.imm_type = cap_type;
    cap_entry.illegal  = cap_illegal;
  end

  assign in_ready_o     = (state_q != StTwo) & ~flush_i;
  assign out_valid_o    = (state_q != StEmpty);
  assign in_fire        = in_valid_i & in_ready_o;
  assign out_fire       = out_valid_o & out_ready_i;
  assign out_instr_o    = main_q.instr;
  assign out_pc_o       = main_q.pc;
  assign out_imm_o      = main_q.imm;
  assign out_imm_type_o = main_q.imm_type;
  assign out_illegal_o  = main_q.illegal;
  assign stall_cnt_o    = stall_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (in_fire) begin
          state_d = StOne;
          main_d  = cap_entry;
        end
      end
      StOne: begin
        if (in_fire && out_fire) begin
          main_d = cap_entry;
        end else if (in_fire) begin
          state_d = StTwo;
          skid_d  = cap_entry;
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (out_fire) begin
          state_d = StOne;
          main_d  = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush wins over any capture; in_ready_o is already low so nothing new lands.
    if (flush_i) begin
      state_d = StEmpty;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid_o && !out_ready_i && (stall_q != '1)) begin
      stall_d = stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Randomised and directed checks of instr_decode_ctrl against a queue-based reference model.
module tb_instr_decode_ctrl;

  localparam int unsigned W = 16;
  localparam int unsigned StallMax = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [31:0]   in_instr_i = '0;
  logic [31:0]   in_pc_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [31:0]   out_instr_o, out_pc_o, out_imm_o;
  logic [2:0]    out_imm_type_o;
  logic          out_illegal_o;
  logic [W-1:0]  stall_cnt_o;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  t;
    logic        ill;
  } exp_t;

  exp_t mq[$];
  int   mstall = 0;
  int   tests = 0;
  int   fails = 0;

  instr_decode_ctrl #(.STALL_CNT_W(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_instr_i     (in_instr_i),
    .in_pc_i        (in_pc_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_instr_o    (out_instr_o),
    .out_pc_o       (out_pc_o),
    .out_imm_o      (out_imm_o),
    .out_imm_type_o (out_imm_type_o),
    .out_illegal_o  (out_illegal_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    int   v;
    e.instr = i;
    e.pc    = pc;
    e.imm   = 0;
    e.t     = 0;
    e.ill   = 0;
    case (i[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: begin e.t = 1; v = int'($signed(i[31:20])); e.imm = v; end
      7'h23: begin e.t = 2; v = int'($signed({i[31:25], i[11:7]})); e.imm = v; end
      7'h63: begin
        e.t = 3; v = int'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); e.imm = v;
      end
      7'h37, 7'h17: begin e.t = 4; e.imm = i & 32'hFFFF_F000; end
      7'h6F: begin
        e.t = 5; v = int'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); e.imm = v;
      end
      7'h33: e.t = 0;
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: advances on the model's own occupancy, never on DUT state.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        mstall = 0;
      end else begin
        automatic bit infire  = in_valid_i && (mq.size() < 2) && !flush_i;
        automatic bit outfire = (mq.size() > 0) && out_ready_i;
        if (mq.size() > 0 && !out_ready_i && mstall < StallMax) mstall++;
        if (outfire) void'(mq.pop_front());
        if (flush_i) mq.delete();
        else if (infire) mq.push_back(ref_decode(in_instr_i, in_pc_i));
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid", 32'(out_valid_o), 32'(mq.size() > 0));
      chk("in_ready", 32'(in_ready_o), 32'((mq.size() < 2) && !flush_i));
      chk("stall_cnt", 32'(stall_cnt_o), mstall);
      if (!rst_n) begin
        chk("rst_instr", out_instr_o, 0);
        chk("rst_imm", out_imm_o, 0);
        chk("rst_type_ill", {out_imm_type_o, out_illegal_o}, 0);
      end else if (mq.size() > 0) begin
        chk("out_instr", out_instr_o, mq[0].instr);
        chk("out_pc", out_pc_o, mq[0].pc);
        chk("out_imm", out_imm_o, mq[0].imm);
        chk("out_type", 32'(out_imm_type_o), 32'(mq[0].t));
        chk("out_illegal", 32'(out_illegal_o), 32'(mq[0].ill));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [31:0] stream [5] = '{32'hFFF00093, 32'hFE20AC23, 32'hFE000EE3, 32'h123452B7,
                              32'h001000EF};
  logic [31:0] simm [5] = '{32'hFFFFFFFF, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h12345000,
                            32'h00000800};
  logic [2:0]  stype [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
  logic [6:0]  opcs [11] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17,
                             7'h6F, 7'h33, 7'h7F};

  initial begin
    int s0;
    // Reset values, including combinational in_ready while held in reset.
    #1;
    chk("reset_valid", 32'(out_valid_o), 0);
    chk("reset_ready", 32'(in_ready_o), 1);
    chk("reset_stall", 32'(stall_cnt_o), 0);
    step();
    rst_n = 1'b1;
    step();

    // Format stream, one cycle after acceptance each.
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_instr_i = stream[k];
      in_pc_i    = 32'h100 + 4 * k;
      step();
      chk("stream_valid", 32'(out_valid_o), 1);
      chk("stream_imm", out_imm_o, simm[k]);
      chk("stream_type", 32'(out_imm_type_o), 32'(stype[k]));
    end
    in_valid_i = 1'b0;
    step();

    // Illegal and R-type.
    in_valid_i = 1'b1;
    in_instr_i = 32'hFFFFFFFF;
    step();
    chk("illegal_flag", 32'(out_illegal_o), 1);
    chk("illegal_type", 32'(out_imm_type_o), 0);
    chk("illegal_imm", out_imm_o, 0);
    in_instr_i = 32'h00000033;
    step();
    chk("rtype_flag", 32'(out_illegal_o), 0);
    chk("rtype_type", 32'(out_imm_type_o), 0);
    in_valid_i = 1'b0;
    step();

    // Back-pressure: three offered, two held, ordered drain, exact stall count.
    s0 = int'(stall_cnt_o);
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_instr_i  = 32'h00A00093; step();
    in_instr_i  = 32'h00B00093; step();
    chk("full_ready", 32'(in_ready_o), 0);
    in_instr_i  = 32'h00C00093; step();
    in_valid_i  = 1'b0;
    step(); step(); step();
    chk("stall_delta", 32'(int'(stall_cnt_o) - s0), 5);
    chk("hold_first", out_instr_o, 32'h00A00093);
    out_ready_i = 1'b1;
    step();
    chk("drain_second", out_instr_o, 32'h00B00093);
    step();
    chk("drain_empty", 32'(out_valid_o), 0);

    // Flush while full with a competing input.
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_instr_i  = 32'h00100013; step();
    in_instr_i  = 32'h00200013; step();
    flush_i    = 1'b1;
    in_instr_i = 32'h00300013;
    #1;
    chk("flush_ready", 32'(in_ready_o), 0);
    step();
    chk("flush_valid", 32'(out_valid_o), 0);
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    step();
    chk("flush_no_accept", 32'(out_valid_o), 0);

    // Asynchronous reset while full.
    in_valid_i = 1'b1;
    in_instr_i = 32'h00400013; step();
    in_instr_i = 32'h00500013; step();
    in_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid_o), 0);
    chk("arst_instr", out_instr_o, 0);
    chk("arst_imm", out_imm_o, 0);
    chk("arst_stall", 32'(stall_cnt_o), 0);
    chk("arst_ready", 32'(in_ready_o), 1);
    step(); step();
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    in_instr_i  = 32'h00600013;
    step();
    in_valid_i = 1'b0;
    chk("post_rst_valid", 32'(out_valid_o), 1);
    chk("post_rst_instr", out_instr_o, 32'h00600013);
    step();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      in_valid_i  = ($urandom_range(0, 3) != 0);
      out_ready_i = ($urandom_range(0, 2) != 0);
      flush_i     = ($urandom_range(0, 31) == 0);
      in_instr_i  = {$urandom()} & 32'hFFFF_FF80;
      in_instr_i[6:0] = ($urandom_range(0, 7) == 0) ? 7'($urandom()) :
                        opcs[$urandom_range(0, 10)];
      in_pc_i     = $urandom();
      step();
    end
    flush_i    = 1'b0;
    in_valid_i = 1'b0;

    // Saturation of the stall counter.
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_instr_i  = 32'h00700013;
    step();
    in_valid_i = 1'b0;
    repeat (70000) @(posedge clk);
    #2;
    chk("stall_saturate", 32'(stall_cnt_o), 32'hFFFF);
    step();
    chk("stall_no_wrap", 32'(stall_cnt_o), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
